// File: rtl/dbg_uart_rx_if.sv
// Byte delivery bundle of the debug UART receiver.
// The receiver drives it through the master modport; the tap's RX packer
// reads it through the slave modport. There is no backpressure signal.
interface dbg_uart_rx_if;
    logic [7:0] rx_data_o;   // last received byte, held between strobes
    logic       rx_valid_o;  // one-cycle strobe per completed frame
    logic       rx_err_o;    // parity or framing fault, qualified by rx_valid_o

    modport master (
        output rx_data_o,
        output rx_valid_o,
        output rx_err_o
    );

    modport slave (
        input  rx_data_o,
        input  rx_valid_o,
        input  rx_err_o
    );
endinterface

// File: rtl/dbg_uart_rx.sv
// Debug UART receive front end.
// Oversamples the asynchronous rx_i line on clk, finds the start edge,
// samples each bit near its centre with a period counter and delivers one
// byte per frame as a single-cycle strobe together with an error flag.
// Frame: start(0), 8 data bits LSB first, optional parity, stop(1).
module dbg_uart_rx #(
    parameter int SYNC_STAGES = 2,  // flops in the rx_i synchronizer, >= 2
    parameter int PARITY_EN   = 1,  // 1: a parity bit follows the data bits
    parameter int PARITY_ODD  = 0   // 1: odd parity, 0: even parity
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic [31:0]   clk_div_i,  // bit period minus one, in clk cycles
    input  logic          rx_i,       // asynchronous serial line, idles high
    dbg_uart_rx_if.master rx_if
);

    localparam bit LP_PAR_EN  = (PARITY_EN != 0);
    localparam bit LP_PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer and edge-detect delay
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_s_d;
    logic                   w_rx_s;

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // Shift rx_i through the synchronizer chain; flops reset to the idle level
    // so that reset never manufactures a start edge.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_sync   <= '1;
            r_rx_s_d <= 1'b1;
        end else begin
            r_sync[0] <= rx_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_rx_s_d <= w_rx_s;
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_next;
    logic [31:0] r_div;
    logic [31:0] w_div_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_next;
    logic        r_par;
    logic        w_par_next;
    logic [7:0]  r_data;
    logic [7:0]  w_data_next;
    logic        r_valid;
    logic        w_valid_next;
    logic        r_err;
    logic        w_err_next;

    logic        w_tick;
    logic        w_start_edge;
    logic        w_perr;
    logic        w_ferr;

    // A sample is taken in the cycle the counter has run down to zero.
    assign w_tick       = (r_cnt == 32'd0);
    // A fresh high-to-low transition is required; a line held low never restarts.
    assign w_start_edge = ~w_rx_s & r_rx_s_d;
    // Parity check covers data, received parity bit and the selected sense.
    assign w_perr       = LP_PAR_EN ? (^r_shift ^ r_par ^ LP_PAR_ODD) : 1'b0;
    assign w_ferr       = ~w_rx_s;

    // Register the state machine, counter, datapath and output strobe.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_shift <= '0;
            r_idx   <= '0;
            r_par   <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_div   <= w_div_next;
            r_shift <= w_shift_next;
            r_idx   <= w_idx_next;
            r_par   <= w_par_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
            r_err   <= w_err_next;
        end
    end

    // Next-state, bit-counter and sample actions for each frame phase.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_div_next   = r_div;
        w_shift_next = r_shift;
        w_idx_next   = r_idx;
        w_par_next   = r_par;
        w_data_next  = r_data;
        w_valid_next = 1'b0;
        w_err_next   = r_err;

        if (r_state != S_IDLE) begin
            // Half a period lands the first sample mid start bit; full
            // periods from there keep every later sample mid bit.
            if (!w_tick) begin
                w_cnt_next = r_cnt - 32'd1;
            end else begin
                w_cnt_next = r_div;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    // The divider is frozen for the whole frame.
                    w_state_next = S_START;
                    w_div_next   = clk_div_i;
                    w_cnt_next   = clk_div_i >> 1;
                end
            end

            S_START: begin
                if (w_tick) begin
                    if (w_rx_s) begin
                        // Line back high at mid start bit: treat as a glitch.
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_DATA;
                        w_idx_next   = 3'd0;
                    end
                end
            end

            S_DATA: begin
                if (w_tick) begin
                    w_shift_next[r_idx] = w_rx_s;
                    if (r_idx == 3'd7) begin
                        w_state_next = LP_PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end
            end

            S_PARITY: begin
                if (w_tick) begin
                    w_par_next   = w_rx_s;
                    w_state_next = S_STOP;
                end
            end

            S_STOP: begin
                if (w_tick) begin
                    // Deliver the byte even when it is flagged bad.
                    w_state_next = S_IDLE;
                    w_valid_next = 1'b1;
                    w_data_next  = r_shift;
                    w_err_next   = w_perr | w_ferr;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign rx_if.rx_data_o  = r_data;
    assign rx_if.rx_valid_o = r_valid;
    assign rx_if.rx_err_o   = r_err;

endmodule

// File: tb/tb_dbg_uart_rx.sv
// Self-checking bench for dbg_uart_rx.
// Two instances: A with even parity, B without a parity bit. Frames are
// driven at exactly P cycles per bit; a monitor logs every strobe with its
// cycle stamp, and each test compares that log against frames it built.
module tb_dbg_uart_rx;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] clk_div = 32'd3;
    logic        rx_a = 1'b1;
    logic        rx_b = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int         c;
        logic [7:0] d;
        logic       e;
    } pulse_t;

    pulse_t qa[$];
    pulse_t qb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dbg_uart_rx_if if_a ();
    dbg_uart_rx_if if_b ();

    dbg_uart_rx #(.SYNC_STAGES(SYNC), .PARITY_EN(1), .PARITY_ODD(0)) u_a (
        .clk       (clk),
        .rst_i     (rst),
        .clk_div_i (clk_div),
        .rx_i      (rx_a),
        .rx_if     (if_a)
    );

    dbg_uart_rx #(.SYNC_STAGES(SYNC), .PARITY_EN(0), .PARITY_ODD(1)) u_b (
        .clk       (clk),
        .rst_i     (rst),
        .clk_div_i (clk_div),
        .rx_i      (rx_b),
        .rx_if     (if_b)
    );

    // Log every strobe, sampled mid-cycle.
    always @(negedge clk) begin
        pulse_t p;
        if (if_a.rx_valid_o === 1'b1) begin
            p.c = cyc; p.d = if_a.rx_data_o; p.e = if_a.rx_err_o;
            qa.push_back(p);
        end
        if (if_b.rx_valid_o === 1'b1) begin
            p.c = cyc; p.d = if_b.rx_data_o; p.e = if_b.rx_err_o;
            qb.push_back(p);
        end
    end

    // Drive one frame, starting on a negedge and ending on the negedge after
    // the stop bit; the line is left at the stop level. c0 = cycle stamp at
    // which the start bit was put on the line.
    task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                              input bit par_flip, input bit stop_bit, input int div,
                              input bit scramble, output int c0);
        logic [11:0] bits;
        int          nb;
        logic        par;
        // Even parity: the parity bit makes the total count of ones even.
        par = (($countones(d) % 2) == 1) ^ par_flip;
        bits = '0;
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin
            bits[nb] = d[i]; nb++;
        end
        if (par_en) begin
            bits[nb] = par; nb++;
        end
        bits[nb] = stop_bit; nb++;
        clk_div = 32'(div);
        c0 = cyc;
        for (int i = 0; i < nb; i++) begin
            if (sel) rx_b = bits[i]; else rx_a = bits[i];
            if (scramble && i == 1) clk_div = $urandom;
            repeat (div + 1) @(negedge clk);
        end
    endtask

    // Cycle stamp at which the strobe for a frame launched at c0 must appear.
    function automatic int exp_cyc(input int c0, input int div, input bit par_en);
        int n_stop;
        n_stop = par_en ? 10 : 9;
        return c0 + 1 + SYNC + 1 + (div / 2) + n_stop * (div + 1);
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        if (if_a.rx_valid_o !== 1'b0) begin
            $display("FAIL reset_valid: got %b want 0", if_a.rx_valid_o); n_err++;
        end
        n_cmp++;
        if (if_a.rx_data_o !== 8'h00) begin
            $display("FAIL reset_data: got %h want 00", if_a.rx_data_o); n_err++;
        end
        n_cmp++;
        if (if_a.rx_err_o !== 1'b0) begin
            $display("FAIL reset_err: got %b want 0", if_a.rx_err_o); n_err++;
        end
        n_cmp++;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        if (qa.size() != 0 || qb.size() != 0) begin
            $display("FAIL reset_idle_pulses: got %0d/%0d want 0/0", qa.size(), qb.size()); n_err++;
        end
        n_cmp++;
        $display("test_reset done");
    endtask

    task automatic test_good_frame();
        int c0;
        qa.delete();
        send_frame(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 3, 1'b0, c0);
        repeat (8) @(negedge clk);
        if (qa.size() != 1) begin
            $display("FAIL good_count: got %0d want 1", qa.size()); n_err++;
        end else begin
            if (qa[0].d !== 8'hA5) begin
                $display("FAIL good_data: got %h want a5", qa[0].d); n_err++;
            end
            n_cmp++;
            if (qa[0].e !== 1'b0) begin
                $display("FAIL good_err: got %b want 0", qa[0].e); n_err++;
            end
            n_cmp++;
            // Start edge registers at c0+3; strobe is 42 cycles later.
            if (qa[0].c != c0 + 3 + 42) begin
                $display("FAIL good_timing: got %0d want %0d", qa[0].c - c0, 45); n_err++;
            end
            n_cmp++;
        end
        n_cmp++;
        $display("test_good_frame data=a5 pulses=%0d", qa.size());
    endtask

    task automatic test_parity_err();
        int c0;
        qa.delete();
        send_frame(1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 3, 1'b0, c0);
        repeat (8) @(negedge clk);
        if (qa.size() != 1) begin
            $display("FAIL perr_count: got %0d want 1", qa.size()); n_err++;
        end else begin
            if (qa[0].d !== 8'h01 || qa[0].e !== 1'b1) begin
                $display("FAIL perr_frame: got %h/%b want 01/1", qa[0].d, qa[0].e); n_err++;
            end
            n_cmp++;
        end
        n_cmp++;
        $display("test_parity_err data=01 pulses=%0d", qa.size());
    endtask

    task automatic test_framing_break();
        int c0;
        qa.delete();
        send_frame(1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 3, 1'b0, c0);
        repeat (40) @(negedge clk);
        if (qa.size() != 1) begin
            $display("FAIL break_count: got %0d want 1", qa.size()); n_err++;
        end else begin
            if (qa[0].d !== 8'h3C || qa[0].e !== 1'b1) begin
                $display("FAIL break_frame: got %h/%b want 3c/1", qa[0].d, qa[0].e); n_err++;
            end
            n_cmp++;
        end
        n_cmp++;
        rx_a = 1'b1;
        repeat (10) @(negedge clk);
        qa.delete();
        send_frame(1'b0, 8'h7E, 1'b1, 1'b0, 1'b1, 3, 1'b0, c0);
        repeat (8) @(negedge clk);
        if (qa.size() != 1) begin
            $display("FAIL after_break_count: got %0d want 1", qa.size()); n_err++;
        end else begin
            if (qa[0].d !== 8'h7E || qa[0].e !== 1'b0) begin
                $display("FAIL after_break_frame: got %h/%b want 7e/0", qa[0].d, qa[0].e); n_err++;
            end
            n_cmp++;
        end
        n_cmp++;
        $display("test_framing_break done");
    endtask

    task automatic test_glitch();
        int c0;
        qa.delete();
        clk_div = 32'd7;
        rx_a = 1'b0;
        repeat (2) @(negedge clk);
        rx_a = 1'b1;
        repeat (30) @(negedge clk);
        if (qa.size() != 0) begin
            $display("FAIL glitch_pulses: got %0d want 0", qa.size()); n_err++;
        end
        n_cmp++;
        send_frame(1'b0, 8'h81, 1'b1, 1'b0, 1'b1, 7, 1'b0, c0);
        repeat (8) @(negedge clk);
        if (qa.size() != 1) begin
            $display("FAIL glitch_next_count: got %0d want 1", qa.size()); n_err++;
        end else begin
            if (qa[0].d !== 8'h81 || qa[0].e !== 1'b0 || qa[0].c != exp_cyc(c0, 7, 1'b1)) begin
                $display("FAIL glitch_next_frame: got %h/%b@%0d want 81/0@%0d",
                         qa[0].d, qa[0].e, qa[0].c - c0, exp_cyc(c0, 7, 1'b1) - c0);
                n_err++;
            end
            n_cmp++;
        end
        n_cmp++;
        $display("test_glitch done");
    endtask

    task automatic test_reset_midframe();
        int c0;
        qa.delete();
        clk_div = 32'd3;
        rx_a = 1'b0;                     // start bit
        repeat (4) @(negedge clk);
        rx_a = 1'b1;                     // data bits 0..3 of 0xFF
        repeat (16) @(negedge clk);
        repeat (2) @(negedge clk);       // middle of data bit 4
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (if_a.rx_valid_o !== 1'b0 || if_a.rx_data_o !== 8'h00 || if_a.rx_err_o !== 1'b0) begin
            $display("FAIL midreset_outputs: got %b/%h/%b want 0/00/0",
                     if_a.rx_valid_o, if_a.rx_data_o, if_a.rx_err_o);
            n_err++;
        end
        n_cmp++;
        repeat (60) @(negedge clk);
        if (qa.size() != 0) begin
            $display("FAIL midreset_pulses: got %0d want 0", qa.size()); n_err++;
        end
        n_cmp++;
        send_frame(1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 3, 1'b0, c0);
        repeat (8) @(negedge clk);
        if (qa.size() != 1) begin
            $display("FAIL midreset_next_count: got %0d want 1", qa.size()); n_err++;
        end else begin
            if (qa[0].d !== 8'h5A || qa[0].e !== 1'b0) begin
                $display("FAIL midreset_next_frame: got %h/%b want 5a/0", qa[0].d, qa[0].e); n_err++;
            end
            n_cmp++;
        end
        n_cmp++;
        $display("test_reset_midframe done");
    endtask

    task automatic test_back_to_back();
        int c0;
        int c1;
        qa.delete();
        send_frame(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3, 1'b0, c0);
        send_frame(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 3, 1'b0, c1);
        repeat (8) @(negedge clk);
        if (qa.size() != 2) begin
            $display("FAIL b2b_par_count: got %0d want 2", qa.size()); n_err++;
        end else begin
            if (qa[0].d !== 8'h00 || qa[1].d !== 8'hFF || qa[0].e !== 1'b0 || qa[1].e !== 1'b0) begin
                $display("FAIL b2b_par_frames: got %h/%b %h/%b want 00/0 ff/0",
                         qa[0].d, qa[0].e, qa[1].d, qa[1].e);
                n_err++;
            end
            n_cmp++;
            if (qa[1].c - qa[0].c != 44) begin
                $display("FAIL b2b_par_spacing: got %0d want 44", qa[1].c - qa[0].c); n_err++;
            end
            n_cmp++;
        end
        n_cmp++;
        qb.delete();
        send_frame(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3, 1'b0, c0);
        send_frame(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 3, 1'b0, c1);
        repeat (8) @(negedge clk);
        if (qb.size() != 2) begin
            $display("FAIL b2b_nopar_count: got %0d want 2", qb.size()); n_err++;
        end else begin
            if (qb[0].d !== 8'h00 || qb[1].d !== 8'hFF || qb[0].e !== 1'b0 || qb[1].e !== 1'b0) begin
                $display("FAIL b2b_nopar_frames: got %h/%b %h/%b want 00/0 ff/0",
                         qb[0].d, qb[0].e, qb[1].d, qb[1].e);
                n_err++;
            end
            n_cmp++;
            if (qb[1].c - qb[0].c != 40 || qb[0].c != exp_cyc(c0, 3, 1'b0)) begin
                $display("FAIL b2b_nopar_timing: got spacing %0d start %0d want 40 %0d",
                         qb[1].c - qb[0].c, qb[0].c - c0, exp_cyc(c0, 3, 1'b0) - c0);
                n_err++;
            end
            n_cmp++;
        end
        n_cmp++;
        $display("test_back_to_back done");
    endtask

    // Random bytes, dividers, parity/stop faults and gaps; the divider input
    // is scrambled mid-frame to confirm it is latched per frame.
    task automatic test_random();
        pulse_t exp_q[$];
        pulse_t e;
        int     c0;
        int     div;
        int     gap;
        bit     pflip;
        bit     stop_bit;
        bit     sel;
        logic [7:0] d;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            exp_q.delete();
            rx_a = 1'b1; rx_b = 1'b1;
            repeat (20) @(negedge clk);
            qa.delete(); qb.delete();
            for (int f = 0; f < 12; f++) begin
                d        = 8'($urandom);
                div      = int'($urandom_range(3, 9));
                pflip    = sel ? 1'b0 : ($urandom_range(0, 3) == 0);
                stop_bit = ($urandom_range(0, 7) != 0);
                send_frame(sel, d, !sel, pflip, stop_bit, div, 1'b1, c0);
                e.c = exp_cyc(c0, div, !sel);
                e.d = d;
                e.e = pflip | ~stop_bit;
                exp_q.push_back(e);
                gap = stop_bit ? int'($urandom_range(0, 5)) : int'($urandom_range(1, 5));
                if (sel) rx_b = 1'b1; else rx_a = 1'b1;
                repeat (gap) @(negedge clk);
            end
            repeat (12) @(negedge clk);
            if (sel) begin
                if (qb.size() != exp_q.size()) begin
                    $display("FAIL rand_nopar_count: got %0d want %0d", qb.size(), exp_q.size()); n_err++;
                end else begin
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (qb[i].d !== exp_q[i].d || qb[i].e !== exp_q[i].e || qb[i].c != exp_q[i].c) begin
                            $display("FAIL rand_nopar_frame%0d: got %h/%b@%0d want %h/%b@%0d", i,
                                     qb[i].d, qb[i].e, qb[i].c, exp_q[i].d, exp_q[i].e, exp_q[i].c);
                            n_err++;
                        end
                        n_cmp++;
                    end
                end
            end else begin
                if (qa.size() != exp_q.size()) begin
                    $display("FAIL rand_par_count: got %0d want %0d", qa.size(), exp_q.size()); n_err++;
                end else begin
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (qa[i].d !== exp_q[i].d || qa[i].e !== exp_q[i].e || qa[i].c != exp_q[i].c) begin
                            $display("FAIL rand_par_frame%0d: got %h/%b@%0d want %h/%b@%0d", i,
                                     qa[i].d, qa[i].e, qa[i].c, exp_q[i].d, exp_q[i].e, exp_q[i].c);
                            n_err++;
                        end
                        n_cmp++;
                    end
                end
            end
            n_cmp++;
            $display("test_random parity_en=%0d frames=%0d", !sel, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_framing_break();
        test_glitch();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dbg_uart_rx.md
# dbg_uart_rx

Serial receive front end for the debug UART tap. The block oversamples the debug host's `rx_i` line on the system clock and delivers one byte per UART frame as a single-cycle strobe. Each byte carries an error flag for parity or framing faults. The tap's receive logic consumes these strobes directly and packs four bytes into its 32-bit RX_DATA word. The block has no backpressure: bytes that arrive while the consumer is full are lost downstream, not here.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: number of flops in the `rx_i` synchronizer (minimum 2).
- `PARITY_EN`, default 1: 1 means a parity bit follows the data bits; 0 means no parity bit.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN`=0.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `clk_div_i`  in  32  bit period minus one, in `clk` cycles (P = `clk_div_i`+1).
- `rx_i`  in  1  asynchronous serial line; idles high.
- `rx_data_o`  out  8  last received byte. Holds its value between strobes.
- `rx_valid_o`  out  1  one-cycle strobe: a frame has completed.
- `rx_err_o`  out  1  error flag for the frame; meaningful only while `rx_valid_o`=1.

## Operation

- Frame format: start (0), 8 data bits LSB first, optional parity, 1 stop (1).
- Synchronizer: `SYNC_STAGES` flops, reset to 1. The last stage is `rx_s`, and `rx_s_d` is `rx_s` delayed by one cycle.
- State machine: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when `rx_s`=0 and `rx_s_d`=1.
  - On this transition, latch `clk_div_i` into `div_q`. A change of `clk_div_i` mid-frame has no effect until the next frame.
  - Load the counter `cnt` with `div_q`>>1.
- Counter rule, in every non-IDLE state:
  - If `cnt`≠0, decrement it.
  - If `cnt`=0, sample `rx_s`, reload `cnt`=`div_q`, and take the state's sample action.
- START sample:
  - 0 → DATA, with bit index 0.
  - 1 → IDLE, with no strobe (glitch rejection).
- DATA sample:
  - Shift the sample into bit[index].
  - Go to PARITY after index 7 if `PARITY_EN`, otherwise to STOP.
- PARITY sample: store the sample as `par_q`.
- STOP sample:
  - Go to IDLE.
  - Next cycle, drive `rx_valid_o`=1, `rx_data_o`=shifted byte, and `rx_err_o`=`perr`|`ferr`.
  - `ferr` = stop sample was 0.
  - `perr` = (^data ^ `par_q` ^ `PARITY_ODD`) when `PARITY_EN`, otherwise 0.
- The byte is delivered even when it has an error.
- After a framing error, start detection needs a fresh 1→0 edge, so a held-low line (break) yields no further frames.

## Timing

- Reset values:
  - `rx_data_o`=0, `rx_valid_o`=0, `rx_err_o`=0.
  - State IDLE; synchronizer flops=1; `cnt`, `div_q`, shift register=0.
- Reset mid-frame: the next cycle is IDLE with no strobe, and the partial byte is discarded.
- Reset dominates a simultaneous stop sample: no strobe is produced.
- Cycle numbering:
  - If `rx_i` falls before the edge at cycle t, the synchronizer shows the edge and IDLE→START registers at cycle k = t+`SYNC_STAGES`.
  - Sample n (n=0 is start) occurs at cycle k+(`div_q`>>1)+n·P.
- Stop sample index N: N=10 with parity, N=9 without.
- `rx_valid_o` is high at cycle k+1+(`div_q`>>1)+N·P, for exactly one cycle.
- `clk_div_i`=0: P=1 and every cycle is a sample. This setting is legal.
- Back-to-back frames: a start edge arriving 1 cycle or more after the stop sample is detected. The minimum frame spacing is (N+1)·P cycles.

## Test plan

All scenarios use `clk_div_i`=3 (P=4) with `PARITY_EN`=1 and even parity unless stated otherwise. Frame timing is driven at exactly P cycles per bit.

- Frame 0xA5 with parity 0 and stop 1 → one `rx_valid_o` pulse, `rx_data_o`=0xA5, `rx_err_o`=0. The pulse occurs at k+42 after start-edge detection at k.
- Frame 0x01 with wrong parity bit 0 → `rx_valid_o` pulse, `rx_data_o`=0x01, `rx_err_o`=1.
- Frame 0x3C with stop bit 0, line then held low for 40 cycles → one pulse with `rx_err_o`=1 and no further pulses. A subsequent valid frame 0x7E is received with `rx_err_o`=0.
- `clk_div_i`=7, `rx_i` low for 2 cycles then high → no `rx_valid_o`, state returns to IDLE. A following valid frame 0x81 is received correctly.
- `rst_i` pulsed 1 cycle during data bit 4 of frame 0xFF → no pulse and outputs 0. The next frame 0x5A gives `rx_data_o`=0x5A, `rx_err_o`=0.
- Frames 0x00 then 0xFF back-to-back with no idle bits → two pulses 44 cycles apart with data 0x00 and 0xFF, both `rx_err_o`=0. Repeat with `PARITY_EN`=0: pulses are 40 cycles apart.
